cache_refill_buffer: RTL and testbench

Line-refill stage directly upstream of the per-word cache-line read mux. Accepts a miss address, issues one burst read of a full line on the memory side, and assembles returning Segment_width beats into a Line_width register. Presents the completed line as mem_rdata to the word mux, and early-forwards the critical (requested) word as soon as its beat arrives.

---
 rtl/cache_refill_buffer_pkg.sv | 21 ++
 rtl/cache_refill_buffer.sv | 126 ++++++++++++
 tb/tb_cache_refill_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_buffer_pkg.sv
// Shared line geometry and FSM encoding for the refill buffer and the
// downstream per-word read mux.
package cache_refill_buffer_pkg;

    localparam int OFFSET_LEN = 6;
    localparam int SEG_W      = 32;
    localparam int ADDR_W     = 32;
    localparam int LINE_W     = 1 << (OFFSET_LEN + 3);
    localparam int BEATS      = LINE_W / SEG_W;
    localparam int IDX_W      = OFFSET_LEN - 2;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cache_refill_buffer.sv
// Line refill: one burst per miss, beats assembled into a full line,
// critical word forwarded as soon as its beat lands.
module cache_refill_buffer
    import cache_refill_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_gnt,
    input  logic              ret_valid,
    input  logic [SEG_W-1:0]  ret_data,
    input  logic              ret_last,
    output logic              crit_valid,
    output logic [SEG_W-1:0]  crit_data,
    output logic              line_valid,
    output logic [LINE_W-1:0] line_data,
    output logic [ADDR_W-1:0] line_addr,
    output logic              line_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] laddr_q, laddr_d;
    logic [IDX_W-1:0]  crit_idx_q, crit_idx_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [SEG_W-1:0]  cdata_q, cdata_d;
    logic              cvld_q, cvld_d;
    logic              err_q, err_d;
    logic              is_last_beat;

    // Byte lanes within a word never select anything here.
    logic unused_lsb;
    assign unused_lsb = ^req_addr[1:0];

    assign is_last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        laddr_d    = laddr_q;
        crit_idx_d = crit_idx_q;
        beat_d     = beat_q;
        line_d     = line_q;
        cdata_d    = cdata_q;
        cvld_d     = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = REQ;
                    base_d     = {req_addr[ADDR_W-1:OFFSET_LEN],
                                  {OFFSET_LEN{1'b0}}};
                    crit_idx_d = req_addr[OFFSET_LEN-1:2];
                    beat_d     = '0;
                    line_d     = '0;
                    cdata_d    = '0;
                    err_d      = 1'b0;
                end
            end
            REQ: begin
                if (rd_gnt) state_d = RECV;
            end
            RECV: begin
                if (ret_valid) begin
                    line_d[beat_q*SEG_W +: SEG_W] = ret_data;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == crit_idx_q) begin
                        cvld_d  = 1'b1;
                        cdata_d = ret_data;
                    end
                    // Count saturates at the final beat; ret_last only ends early.
                    if (ret_last || is_last_beat) begin
                        state_d = DONE;
                        beat_d  = beat_q;
                        err_d   = ret_last ^ is_last_beat;
                        laddr_d = base_q;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            laddr_q    <= '0;
            crit_idx_q <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            cdata_q    <= '0;
            cvld_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            laddr_q    <= laddr_d;
            crit_idx_q <= crit_idx_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            cdata_q    <= cdata_d;
            cvld_q     <= cvld_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rd_req     = (state_q == REQ);
    assign rd_addr    = base_q;
    assign rd_len     = 8'(BEATS - 1);
    assign crit_valid = cvld_q;
    assign crit_data  = cdata_q;
    assign line_valid = (state_q == DONE);
    assign line_err   = (state_q == DONE) && err_q;
    assign line_data  = line_q;
    assign line_addr  = laddr_q;

endmodule

// File: tb/tb_cache_refill_buffer.sv
// Directed and randomized refill transactions checked against a
// segment-array model of the expected line.
module tb_cache_refill_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic [7:0]   rd_len;
    logic         rd_gnt;
    logic         ret_valid;
    logic [31:0]  ret_data;
    logic         ret_last;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_valid;
    logic [511:0] line_data;
    logic [31:0]  line_addr;
    logic         line_err;

    int n_chk  = 0;
    int n_fail = 0;
    int crit_cnt = 0;
    int line_cnt = 0;
    logic [31:0] crit_seen = '0;

    cache_refill_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .rd_gnt    (rd_gnt),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .ret_last  (ret_last),
        .crit_valid(crit_valid),
        .crit_data (crit_data),
        .line_valid(line_valid),
        .line_data (line_data),
        .line_addr (line_addr),
        .line_err  (line_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (crit_valid) begin
            crit_cnt++;
            crit_seen = crit_data;
        end
        if (line_valid) line_cnt++;
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst rd_req", rd_req, 0);
        chk("rst crit_valid", crit_valid, 0);
        chk("rst line_valid", line_valid, 0);
        chk("rst line_err", line_err, 0);
        chk("rst line_data", line_data, 0);
        chk("rst crit_data", crit_data, 0);
        chk("rst line_addr", line_addr, 0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst req_ready", req_ready, 1);
    endtask

    // last_at < 0: no ret_last at all, the line completes on beat 15.
    task automatic txn(input logic [31:0] addr, input int gnt_dly,
                       input int gap_pct, input int last_at,
                       input bit poke, input logic [31:0] next_addr,
                       input bit a0_data);
        logic [31:0]  base;
        logic [31:0]  d[16];
        logic [511:0] exp_line;
        bit           exp_err;
        int           ci, nb, c0, l0;
        base    = addr & 32'hFFFF_FFC0;
        ci      = int'(addr[5:2]);
        nb      = (last_at >= 0) ? last_at + 1 : 16;
        exp_err = (last_at != 15);
        for (int i = 0; i < 16; i++)
            d[i] = a0_data ? 32'hA0 + 32'(i) : ($urandom | 32'h1);
        exp_line = '0;
        for (int i = 0; i < nb; i++) exp_line[i*32 +: 32] = d[i];
        c0 = crit_cnt;
        l0 = line_cnt;

        chk("req_ready idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        chk("rd_req first", rd_req, 1);
        chk("rd_addr", rd_addr, base);
        chk("rd_len", rd_len, 15);
        chk("req_ready busy", req_ready, 0);
        for (int k = 0; k < gnt_dly; k++) begin
            if (poke) begin
                ret_valid = 1'b1;
                ret_data  = 32'hDEAD_0000 + 32'(k);
                ret_last  = 1'b1;
            end
            step();
            chk("rd_req hold", rd_req, 1);
            chk("rd_addr hold", rd_addr, base);
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        rd_gnt    = 1'b1;
        step();
        rd_gnt = 1'b0;
        chk("rd_req drop", rd_req, 0);
        if (poke) begin
            req_valid = 1'b1;
            req_addr  = next_addr;
        end
        for (int i = 0; i < nb; i++) begin
            ret_valid = 1'b0;
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                step();
                chk("gap no line", line_valid, 0);
            end
            ret_valid = 1'b1;
            ret_data  = d[i];
            ret_last  = (i == last_at);
            step();
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            if (poke) chk("req_ready recv", req_ready, 0);
            if (i < nb - 1) chk("no early line", line_valid, 0);
        end
        chk("line_valid", line_valid, 1);
        chk("line_err", line_err, exp_err);
        chk("line_data", line_data, exp_line);
        chk("line_addr", line_addr, base);
        chk("req_ready done", req_ready, 0);
        step();
        chk("line pulse end", line_valid, 0);
        chk("req_ready after", req_ready, 1);
        chk("line pulses", line_cnt - l0, 1);
        chk("crit pulses", crit_cnt - c0, (ci < nb) ? 1 : 0);
        if (ci < nb) begin
            chk("crit seen", crit_seen, d[ci]);
            chk("crit hold", crit_data, d[ci]);
        end
    endtask

    initial begin
        int c0, l0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rd_gnt    = 1'b0;
        ret_valid = 1'b0;
        ret_data  = '0;
        ret_last  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset_vals();

        txn(32'h0000_1048, 2, 0, 15, 1'b0, '0, 1'b1);
        chk("seg2 slice", line_data[95:64], 32'hA2);
        chk("seg15 slice", line_data[511:480], 32'hAF);
        chk("crit A2", crit_data, 32'hA2);

        txn(32'h0000_203C, 1, 40, 15, 1'b0, '0, 1'b0);
        txn(32'h0000_3024, 0, 20, 5, 1'b0, '0, 1'b0);
        txn(32'h0000_5010, 3, 0, 15, 1'b1, 32'h0000_6080, 1'b0);
        txn(32'h0000_6080, 0, 20, -1, 1'b0, '0, 1'b0);
        txn(32'h0000_7000, 10, 0, 15, 1'b0, '0, 1'b0);
        for (int r = 0; r < 3; r++)
            txn($urandom, $urandom_range(4), 30, 15, 1'b0, '0, 1'b0);

        req_valid = 1'b1;
        req_addr  = 32'h0000_400C;
        step();
        req_valid = 1'b0;
        rd_gnt = 1'b1;
        step();
        rd_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ret_valid = 1'b1;
            ret_data  = $urandom | 32'h1;
            step();
        end
        ret_valid = 1'b0;
        chk("crit before rst", crit_data != 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals();
        c0 = crit_cnt;
        l0 = line_cnt;
        for (int i = 0; i < 8; i++) begin
            ret_valid = 1'b1;
            ret_data  = $urandom;
            ret_last  = (i == 7);
            step();
            chk("stray no line", line_valid, 0);
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        step();
        chk("stray crit", crit_cnt - c0, 0);
        chk("stray lines", line_cnt - l0, 0);
        chk("stray idle", req_ready, 1);

        txn(32'h0000_8ABC, 0, 10, 15, 1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
